code_lock_fsm: RTL and testbench

Parametrised button-entry combination lock and the successor to the fixed two-button lock. It takes `btn_0`/`btn_1` presses, compares a complete `CODE_LEN`-digit entry against the stored code and drives `unlock`. Beyond the fixed lock, it adds an inter-press timeout, a failed-attempt counter with timed lockout, and optional runtime re-programming of the code. It is the top-level control block for the lock design.

---
 rtl/code_lock_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_fsm.sv
// code_lock_fsm: button-entry combination lock with inter-press timeout,
// failed-attempt counter with timed lockout, and optional runtime
// re-programming of the code (enabled by defining LOCK_PROGRAM_EN).
// The FSM state is visible on dbg_state for checkers.
module code_lock_fsm #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE           = 5'b11001,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 64,
  parameter int                  TIMEOUT_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           btn_reset_n,
  input  logic                           btn_0,
  input  logic                           btn_1,
`ifdef LOCK_PROGRAM_EN
  input  logic                           btn_prog,
`endif
  output logic                           unlock,
  output logic                           locked_out,
  output logic                           entry_active,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic [2:0]                     dbg_state
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [CW-1:0] CODE_N    = CW'(CODE_LEN);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_LOCKOUT = 3'd3
`ifdef LOCK_PROGRAM_EN
    , S_PROG  = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                b0_q, b1_q;
  // Only the first CODE_LEN-1 digits are stored; the final digit is taken
  // straight from the completing press.
  logic [CODE_LEN-2:0] entry_q, entry_d;
  logic                poison_q, poison_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [LW-1:0]       lock_q, lock_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [CODE_LEN-1:0] code_cur;

  logic                p0, p1, any_press, both_press, tmo_exp;
  logic [CODE_LEN-1:0] shifted;
  logic [CW-1:0]       cnt_inc;
  logic [FW-1:0]       fail_inc;

`ifdef LOCK_PROGRAM_EN
  logic                prog_q;
  logic                prog_rise;
  logic [CODE_LEN-1:0] code_q, code_d;
  assign prog_rise = btn_prog & ~prog_q;
  assign code_cur  = code_q;
`else
  assign code_cur  = CODE;
`endif

  assign p0         = btn_0 & ~b0_q;
  assign p1         = btn_1 & ~b1_q;
  assign any_press  = p0 | p1;
  assign both_press = p0 & p1;
  assign shifted    = {entry_q, p1};
  assign cnt_inc    = cnt_q + CW'(1);
  assign fail_inc   = fail_q + FW'(1);
  assign tmo_exp    = (tmo_q == TW'(1));

  assign fail_count = fail_q;
  assign dbg_state  = state_q;

  // Next-state and datapath update; a press always wins over a timeout.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    poison_d = poison_q;
    cnt_d    = cnt_q;
    tmo_d    = (tmo_q != '0) ? tmo_q - TW'(1) : '0;
    lock_d   = lock_q;
    fail_d   = fail_q;
`ifdef LOCK_PROGRAM_EN
    code_d   = code_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_press) begin
          entry_d  = shifted[CODE_LEN-2:0];
          poison_d = both_press;
          cnt_d    = CW'(1);
          tmo_d    = TMO_LOAD;
          state_d  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (any_press) begin
          entry_d  = shifted[CODE_LEN-2:0];
          poison_d = poison_q | both_press;
          cnt_d    = cnt_inc;
          tmo_d    = TMO_LOAD;
          if (cnt_inc == CODE_N) begin
            cnt_d = '0;
            if (!(poison_q | both_press) && (shifted == code_cur)) begin
              state_d = S_OPEN;
              fail_d  = '0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                state_d = S_LOCKOUT;
                lock_d  = LOCK_LOAD;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end else if (tmo_exp) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (any_press) begin
          state_d = S_IDLE;
`ifdef LOCK_PROGRAM_EN
        end else if (prog_rise) begin
          cnt_d    = '0;
          poison_d = 1'b0;
          tmo_d    = TMO_LOAD;
          state_d  = S_PROG;
`endif
        end
      end
      S_LOCKOUT: begin
        lock_d = lock_q - LW'(1);
        if (lock_q == LW'(1)) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
`ifdef LOCK_PROGRAM_EN
      S_PROG: begin
        if (any_press) begin
          entry_d  = shifted[CODE_LEN-2:0];
          poison_d = poison_q | both_press;
          cnt_d    = cnt_inc;
          tmo_d    = TMO_LOAD;
          if (cnt_inc == CODE_N) begin
            cnt_d = '0;
            if (poison_q | both_press) begin
              state_d = S_OPEN;
            end else begin
              code_d  = shifted;
              state_d = S_IDLE;
            end
          end
        end else if (tmo_exp) begin
          cnt_d   = '0;
          state_d = S_OPEN;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!btn_reset_n) begin
      state_q      <= S_IDLE;
      b0_q         <= 1'b0;
      b1_q         <= 1'b0;
      entry_q      <= '0;
      poison_q     <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      lock_q       <= '0;
      fail_q       <= '0;
      unlock       <= 1'b0;
      locked_out   <= 1'b0;
      entry_active <= 1'b0;
`ifdef LOCK_PROGRAM_EN
      prog_q       <= 1'b0;
      code_q       <= CODE;
`endif
    end else begin
      state_q      <= state_d;
      b0_q         <= btn_0;
      b1_q         <= btn_1;
      entry_q      <= entry_d;
      poison_q     <= poison_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      lock_q       <= lock_d;
      fail_q       <= fail_d;
      unlock       <= (state_d == S_OPEN);
      locked_out   <= (state_d == S_LOCKOUT);
`ifdef LOCK_PROGRAM_EN
      prog_q       <= btn_prog;
      code_q       <= code_d;
      entry_active <= (state_d == S_ENTRY) || (state_d == S_PROG);
`else
      entry_active <= (state_d == S_ENTRY);
`endif
    end
  end

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm: directed and randomized stimulus for code_lock_fsm,
// checked every cycle against a behavioural model of the lock rules.
module tb_code_lock_fsm;

  localparam int          CODE_LEN  = 5;
  localparam logic [4:0]  CODE      = 5'b11001;
  localparam int          MAX_FAILS = 3;
  localparam int          LOCKOUT   = 64;
  localparam int          TIMEOUT   = 32;
  localparam int          FW        = $clog2(MAX_FAILS + 1);
  localparam int          W         = 3 + FW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          btn_reset_n, btn_0, btn_1;
`ifdef LOCK_PROGRAM_EN
  logic          btn_prog;
`endif
  logic          unlock, locked_out, entry_active;
  logic [FW-1:0] fail_count;
  logic [2:0]    dbg_state;

  code_lock_fsm dut (
    .clk          (clk),
    .btn_reset_n  (btn_reset_n),
    .btn_0        (btn_0),
    .btn_1        (btn_1),
`ifdef LOCK_PROGRAM_EN
    .btn_prog     (btn_prog),
`endif
    .unlock       (unlock),
    .locked_out   (locked_out),
    .entry_active (entry_active),
    .fail_count   (fail_count),
    .dbg_state    (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lock described as: digits typed so far, open flag, remaining lockout
  // time, programming flag, and cycles since the last press.
  logic [W-1:0] exp_q[$];
  int           m_digits[$];   // 0, 1, or 2 for a poisoned digit
  bit           m_open, m_prog, m_valid;
  int           m_lock_left, m_quiet, m_fails;
  logic [4:0]   m_code;
  bit           m_b0q, m_b1q, m_pq;

  always @(posedge clk) begin : model
    bit p0, p1, prise, poisoned;
    int val;
    p0 = btn_0 && !m_b0q;
    p1 = btn_1 && !m_b1q;
`ifdef LOCK_PROGRAM_EN
    prise = btn_prog && !m_pq;
    m_pq  = btn_prog;
`else
    prise = 1'b0;
`endif
    m_b0q = btn_0;
    m_b1q = btn_1;
    if (!btn_reset_n) begin
      m_digits.delete();
      m_open = 0; m_prog = 0; m_lock_left = 0; m_quiet = 0; m_fails = 0;
      m_code = CODE; m_b0q = 0; m_b1q = 0; m_pq = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_fails = 0;
      end else if (m_open) begin
        if (p0 || p1) m_open = 0;
        else if (prise) begin
          m_open = 0; m_prog = 1; m_quiet = 0; m_digits.delete();
        end
      end else if (p0 || p1) begin
        m_digits.push_back((p0 && p1) ? 2 : (p1 ? 1 : 0));
        m_quiet = 0;
        if (m_digits.size() == CODE_LEN) begin
          val = 0; poisoned = 0;
          foreach (m_digits[i]) begin
            if (m_digits[i] == 2) poisoned = 1;
            val = val * 2 + (m_digits[i] == 0 ? 0 : 1);
          end
          m_digits.delete();
          if (m_prog) begin
            m_prog = 0;
            if (poisoned) m_open = 1;
            else m_code = 5'(val);
          end else if (!poisoned && val == int'(m_code)) begin
            m_open = 1; m_fails = 0;
          end else begin
            m_fails++;
            if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT;
          end
        end
      end else if (m_digits.size() > 0 || m_prog) begin
        m_quiet++;
        if (m_quiet >= TIMEOUT) begin
          if (m_prog) m_open = 1;
          m_prog = 0;
          m_digits.delete();
        end
      end
    end
    if (m_valid)
      exp_q.push_back({m_open, (m_lock_left > 0), (m_prog || m_digits.size() > 0),
                       FW'(m_fails)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("unlock",       int'(unlock),       int'(e[W-1]));
      check("locked_out",   int'(locked_out),   int'(e[W-2]));
      check("entry_active", int'(entry_active), int'(e[W-3]));
      check("fail_count",   int'(fail_count),   int'(e[FW-1:0]));
    end
  end

  // Length of the most recent completed locked_out run.
  int lo_run = 0, last_lo_run = 0;
  always @(negedge clk) begin
    if (locked_out === 1'b1) lo_run++;
    else if (lo_run != 0) begin
      last_lo_run = lo_run;
      lo_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // d: 0 = btn_0, 1 = btn_1, 2 = both together
  task automatic press(input int d);
    @(negedge clk);
    if (d != 1) btn_0 = 1'b1;
    if (d != 0) btn_1 = 1'b1;
    @(negedge clk);
    btn_0 = 1'b0;
    btn_1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_code(input logic [4:0] c, input int gap);
    for (int i = CODE_LEN - 1; i >= 0; i--) begin
      press(int'(c[i]));
      if (i > 0) idle(gap);
    end
  endtask

  task automatic reset_pulse_check(input string tag);
    @(negedge clk);
    btn_reset_n = 1'b0;
    @(negedge clk);
    check({tag, "_unlock"},     int'(unlock),       0);
    check({tag, "_locked_out"}, int'(locked_out),   0);
    check({tag, "_entry"},      int'(entry_active), 0);
    check({tag, "_fails"},      int'(fail_count),   0);
    btn_reset_n = 1'b1;
  endtask

`ifdef LOCK_PROGRAM_EN
  task automatic pulse_prog();
    @(negedge clk);
    btn_prog = 1'b1;
    @(negedge clk);
    btn_prog = 1'b0;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin : main
    int drop, waited, r;
    btn_reset_n = 1'b0;
    btn_0 = 1'b0;
    btn_1 = 1'b0;
`ifdef LOCK_PROGRAM_EN
    btn_prog = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_unlock", int'(unlock), 0);
    check("reset_fails",  int'(fail_count), 0);
    btn_reset_n = 1'b1;

    // Correct code with 10-cycle spacing, then relock.
    enter_code(CODE, 9);
    check("t1_unlock", int'(unlock), 1);
    check("t1_fails",  int'(fail_count), 0);
    idle(3);
    press(0);
    check("t1_relock", int'(unlock), 0);

    // Three wrong entries lead to a 64-cycle lockout.
    idle(2);
    enter_code(5'b00000, 3);
    check("t2_fail1", int'(fail_count), 1);
    idle(3);
    enter_code(5'b00000, 3);
    check("t2_fail2", int'(fail_count), 2);
    idle(3);
    enter_code(5'b00000, 3);
    check("t2_locked", int'(locked_out), 1);
    enter_code(CODE, 2);
    check("t2_ignored", int'(unlock), 0);
    waited = 0;
    while (locked_out === 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("t2_lockout_ends", int'(waited < 200), 1);
    idle(1);
    check("t2_lock_len", last_lo_run, LOCKOUT);
    check("t2_fails_clr", int'(fail_count), 0);
    enter_code(CODE, 4);
    check("t2_unlock", int'(unlock), 1);
    press(0);

    // Partial entry abandoned: timeout after 32 idle cycles.
    idle(2);
    press(1);
    idle(9);
    press(1);
    drop = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (entry_active !== 1'b1 && drop == 0) drop = i;
    end
    check("t3_drop_cycle", drop, TIMEOUT);
    check("t3_fails", int'(fail_count), 0);
    enter_code(CODE, 5);
    check("t3_unlock", int'(unlock), 1);
    press(0);

    // Poisoned digit, then a held button counting as one press.
    idle(2);
    press(1); idle(3); press(1); idle(3); press(2); idle(3); press(0); idle(3); press(1);
    check("t4_poison_fail", int'(fail_count), 1);
    idle(3);
    @(negedge clk);
    btn_1 = 1'b1;
    repeat (20) @(negedge clk);
    btn_1 = 1'b0;
    idle(3);
    press(1); idle(3); press(0); idle(3); press(0); idle(3); press(1);
    check("t4_hold_one_digit", int'(unlock), 1);
    press(0);

    // Randomized traffic, checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        press($urandom_range(0, 1));
        idle($urandom_range(0, 4));
      end else if (r < 62) begin
        press(2);
      end else if (r < 70) begin
        enter_code(CODE, $urandom_range(1, 3));
      end else if (r < 76) begin
        idle($urandom_range(25, 40));
      end else if (r < 80) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) btn_1 = 1'b1; else btn_0 = 1'b1;
        idle($urandom_range(2, 10));
        btn_0 = 1'b0;
        btn_1 = 1'b0;
      end else if (r < 82) begin
        @(negedge clk);
        btn_reset_n = 1'b0;
        btn_1 = 1'($urandom_range(0, 1));
        @(negedge clk);
        btn_reset_n = 1'b1;
        @(negedge clk);
        btn_1 = 1'b0;
`ifdef LOCK_PROGRAM_EN
      end else if (r < 86) begin
        pulse_prog();
`endif
      end else begin
        idle($urandom_range(1, 70));
      end
    end

    // Reset mid-entry, in OPEN and in LOCKOUT.
    reset_pulse_check("t5_start");
    press(1); idle(2); press(1);
    reset_pulse_check("t5_entry");
    enter_code(CODE, 2);
    check("t5_open", int'(unlock), 1);
    reset_pulse_check("t5_open");
    for (int k = 0; k < MAX_FAILS; k++) begin
      enter_code(5'b00000, 2);
      idle(2);
    end
    check("t5_locked", int'(locked_out), 1);
    reset_pulse_check("t5_lockout");
    // Button held through reset release counts as the first digit.
    @(negedge clk);
    btn_1 = 1'b1;
    btn_reset_n = 1'b0;
    @(negedge clk);
    btn_reset_n = 1'b1;
    @(negedge clk);
    check("t5_held_press", int'(entry_active), 1);
    btn_1 = 1'b0;
    idle(2);
    press(1); idle(2); press(0); idle(2); press(0); idle(2); press(1);
    check("t5_code_default", int'(unlock), 1);
    press(0);

`ifdef LOCK_PROGRAM_EN
    // Re-program the code to 0,1,0,1,0.
    reset_pulse_check("t6_start");
    enter_code(CODE, 3);
    pulse_prog();
    enter_code(5'b01010, 3);
    check("t6_locked_after_prog", int'(unlock), 0);
    check("t6_entry_after_prog", int'(entry_active), 0);
    idle(3);
    enter_code(CODE, 3);
    check("t6_old_code_fails", int'(fail_count), 1);
    idle(3);
    enter_code(5'b01010, 3);
    check("t6_new_code_unlocks", int'(unlock), 1);
    reset_pulse_check("t6_reset");
    enter_code(CODE, 3);
    check("t6_code_reverts", int'(unlock), 1);
`endif

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
